// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment scan multiplexer
package sseg_pkg;

    // Active-low segment patterns, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    localparam logic [6:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    // Digit positions; digit 0 is the rightmost on the board
    localparam logic [1:0] D_STATE = 2'd0;
    localparam logic [1:0] D_ENT   = 2'd1;
    localparam logic [1:0] D_HUN   = 2'd2;
    localparam logic [1:0] D_ENE   = 2'd3;

    // One coherent sample of everything the display shows
    typedef struct packed {
        logic [3:0] state;
        logic [2:0] ent;
        logic [2:0] hun;
        logic [2:0] ene;
    } sample_t;

    // Value shown on a given digit position, statistics zero-extended
    function automatic logic [3:0] digit_value(input sample_t s, input logic [1:0] idx);
        return idx == D_STATE ? s.state :
               idx == D_ENT   ? {1'b0, s.ent} :
               idx == D_HUN   ? {1'b0, s.hun} : {1'b0, s.ene};
    endfunction

    // Active-low one-hot anode select for a digit position
    function automatic logic [3:0] anode_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: 4-bit value to active-low seven-segment pattern (0-9, A b C d E F)
module hex7seg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[val_i];

endmodule

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: 4-digit common-anode scan with frame-coherent snapshot and ghost blanking
// Optional zero-value blink on digits 1..3 is enabled by defining SSEG_CRITICAL_BLINK_EN.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [2:0] energy,
    input  logic [2:0] hunger,
    input  logic [2:0] entertainment,
    input  logic       upd,
    output logic [6:0] sseg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int RAW_CYCLES   = CLK_HZ / (SCAN_HZ * 4);
    localparam int DIGIT_CYCLES = RAW_CYCLES < 4 ? 4 : RAW_CYCLES;
    localparam int CW           = $clog2(DIGIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          armed_q;
    sample_t       pend_q, shadow_q, sample;
    logic          pend_valid_q;
    logic [6:0]    sseg_q;
    logic          dp_q;
    logic [3:0]    an_q;
    logic          frame_start_q;
    logic          wrap, frame_wrap, active, hide, fs_d;
    logic [3:0]    val;
    logic [6:0]    seg;

    assign sample     = '{state: state, ent: entertainment, hun: hunger, ene: energy};
    assign wrap       = cnt_q == CW'(DIGIT_CYCLES - 1);
    assign frame_wrap = wrap && idx_q == D_ENE;
    assign active     = cnt_q >= CW'(BLANK_CYCLES);
    assign val        = digit_value(shadow_q, idx_q);
    // armed_q suppresses the frame pulse on the very first slot after reset
    assign fs_d       = armed_q && cnt_q == '0 && idx_q == D_STATE;

    hex7seg_decode u_dec (
        .val_i (val),
        .seg_o (seg)
    );

    // Next slot position: count within the slot, step digit on slot wrap
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 1'b1 : idx_q;
    end

`ifdef SSEG_CRITICAL_BLINK_EN
    logic [7:0] frame_cnt_q;

    // Frame counter paces the blink; upper half of its range shows zero digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= fs_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    assign hide = idx_q != D_STATE && val == 4'd0 && !frame_cnt_q[7];
`else
    assign hide = 1'b0;
`endif

    // Scan position and first-frame arming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= D_STATE;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            armed_q <= armed_q | frame_wrap;
        end
    end

    // Snapshot: upd fills pending; pending moves to shadow only at the frame boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q       <= '0;
            shadow_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_q       <= upd ? sample : pend_q;
            shadow_q     <= frame_wrap && pend_valid_q ? pend_q : shadow_q;
            pend_valid_q <= upd | (pend_valid_q & ~frame_wrap);
        end
    end

    // Registered pin drive: blank phase at slot start, then the selected digit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q          <= 4'b1111;
            sseg_q        <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            an_q          <= active && !hide ? anode_select(idx_q) : 4'b1111;
            sseg_q        <= active && !hide ? seg : SEG_BLANK;
            dp_q          <= !(active && idx_q == D_STATE);
            frame_start_q <= fs_d;
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: vector table, corner sequences and random traffic against a slot-arithmetic model
module tb_sseg_scan_mux;

    localparam int DC = 10;
    localparam int BL = 2;
    localparam int FR = 4 * DC;

    logic       clk = 1'b0, rst = 1'b0, upd = 1'b0;
    logic [3:0] state = '0;
    logic [2:0] energy = '0, hunger = '0, entertainment = '0;
    logic [6:0] sseg;
    logic       dp, frame_start;
    logic [3:0] an;

    sseg_scan_mux #(.CLK_HZ(4000), .SCAN_HZ(100), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst), .state(state), .energy(energy), .hunger(hunger),
        .entertainment(entertainment), .upd(upd), .sseg(sseg), .dp(dp), .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0]      st;
        logic [2:0]      en, hu, ent;
        logic [3:0][6:0] seg;
    } vec_t;
    vec_t vt [10];

    int passed = 0, total = 0;
    // model: edges since reset release, displayed sample per digit, pending sample
    int tq, pin_tq;
    int sh [4], pe [4];
    bit pv;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_fs;
    bit         cap_en = 0;
    int         cap_cnt [4];
    logic [6:0] cap_seg [4];
    int         cap_frame;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else passed++;
    endtask

    task automatic model_reset();
        tq = 0;
        pv = 0;
        for (int k = 0; k < 4; k++) begin sh[k] = 0; pe[k] = 0; end
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    endtask

    // Drive one cycle of inputs, predict pins for the coming edge, compare at the next negedge
    task automatic step(input logic u, input logic [3:0] s, input logic [2:0] e, input logic [2:0] h, input logic [2:0] t);
        int p, dg, c;
        bit act, hide;
        upd = u; state = s; energy = e; hunger = h; entertainment = t;
        p = tq % FR; dg = p / DC; c = p % DC;
        act = c >= BL;
        hide = 0;
`ifdef SSEG_CRITICAL_BLINK_EN
        hide = dg != 0 && sh[dg] == 0 && ((tq / FR) % 256) < 128;
`endif
        exp_an  = act && !hide ? ~(4'b0001 << dg) : 4'hF;
        exp_seg = act && !hide ? seg_tab[sh[dg]] : 7'h7F;
        exp_dp  = !(act && dg == 0);
        exp_fs  = p == 0 && tq > 0;
        pin_tq  = tq;
        if (p == FR - 1 && pv) begin
            for (int k = 0; k < 4; k++) sh[k] = pe[k];
            pv = 0;
        end
        if (u) begin pe[0] = s; pe[1] = t; pe[2] = h; pe[3] = e; pv = 1; end
        tq++;
        @(negedge clk);
        chk("pins{an,sseg,dp,fs}", {an, sseg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
        chk("anode_onehot", 32'($countones(~an) <= 1), 32'd1);
        if (cap_en)
            for (int k = 0; k < 4; k++)
                if (an == ~(4'b0001 << k)) begin cap_cnt[k]++; cap_seg[k] = sseg; cap_frame = pin_tq / FR; end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic align(input int r);
        while (tq % FR != r) idle(1);
    endtask

    task automatic cap_clear();
        for (int k = 0; k < 4; k++) begin cap_cnt[k] = 0; cap_seg[k] = 7'h7F; end
    endtask

    task automatic cap_run();
        cap_clear();
        cap_en = 1;
        idle(FR);
        cap_en = 0;
    endtask

    initial begin
        int val, cnt_a, cnt_b;
        bit hid;
        vt[0] = '{4'h5, 3'd7, 3'd3, 3'd0, {seg_tab[7], seg_tab[3], seg_tab[0], seg_tab[5]}};
        vt[1] = '{4'hA, 3'd1, 3'd2, 3'd4, {seg_tab[1], seg_tab[2], seg_tab[4], seg_tab[10]}};
        vt[2] = '{4'hF, 3'd6, 3'd5, 3'd7, {seg_tab[6], seg_tab[5], seg_tab[7], seg_tab[15]}};
        vt[3] = '{4'h0, 3'd2, 3'd6, 3'd1, {seg_tab[2], seg_tab[6], seg_tab[1], seg_tab[0]}};
        vt[4] = '{4'hB, 3'd4, 3'd7, 3'd3, {seg_tab[4], seg_tab[7], seg_tab[3], seg_tab[11]}};
        vt[5] = '{4'hC, 3'd5, 3'd1, 3'd2, {seg_tab[5], seg_tab[1], seg_tab[2], seg_tab[12]}};
        vt[6] = '{4'hD, 3'd3, 3'd4, 3'd5, {seg_tab[3], seg_tab[4], seg_tab[5], seg_tab[13]}};
        vt[7] = '{4'hE, 3'd1, 3'd1, 3'd6, {seg_tab[1], seg_tab[1], seg_tab[6], seg_tab[14]}};
        vt[8] = '{4'h8, 3'd7, 3'd7, 3'd7, {seg_tab[7], seg_tab[7], seg_tab[7], seg_tab[8]}};
        vt[9] = '{4'h9, 3'd2, 3'd3, 3'd4, {seg_tab[2], seg_tab[3], seg_tab[4], seg_tab[9]}};
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_sseg", sseg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_fs", frame_start, 1'b0);
        rst = 1'b1;
        idle(3);
        chk("first_active_an", an, 4'b1110);
        chk("first_active_sseg", sseg, seg_tab[0]);

        // vector table: sample, let it reach the shadow, capture one full frame
        for (int i = 0; i < 10; i++) begin
            align(0);
            step(1, vt[i].st, vt[i].en, vt[i].hu, vt[i].ent);
            align(0);
            cap_run();
            for (int k = 0; k < 4; k++) begin
                val = k == 0 ? vt[i].st : k == 1 ? vt[i].ent : k == 2 ? vt[i].hu : vt[i].en;
                hid = 0;
`ifdef SSEG_CRITICAL_BLINK_EN
                hid = k != 0 && val == 0 && (cap_frame % 256) < 128;
`endif
                chk($sformatf("vec%0d_d%0d_active_cycles", i, k), cap_cnt[k], hid ? 0 : DC - BL);
                if (!hid) chk($sformatf("vec%0d_d%0d_seg", i, k), cap_seg[k], vt[i].seg[k]);
            end
        end

        // coherency: a sample arriving mid digit 2 waits for the frame boundary
        align(0);
        step(1, 4'h2, 3'd5, 3'd6, 3'd1);
        align(0);
        cap_clear();
        cap_en = 1;
        align(25);
        step(1, 4'h9, 3'd1, 3'd2, 3'd3);
        align(0);
        cap_en = 0;
        chk("coh_old_d0", cap_seg[0], seg_tab[2]);
        chk("coh_old_d2", cap_seg[2], seg_tab[6]);
        chk("coh_old_d3", cap_seg[3], seg_tab[5]);
        cap_run();
        chk("coh_new_d0", cap_seg[0], seg_tab[9]);
        chk("coh_new_d2", cap_seg[2], seg_tab[2]);
        chk("coh_new_d3", cap_seg[3], seg_tab[1]);

        // collision: upd on the wrap cycle stays pending for one more frame
        align(0);
        step(1, 4'h4, 3'd1, 3'd1, 3'd1);
        align(FR - 1);
        step(1, 4'hA, 3'd2, 3'd2, 3'd2);
        cap_run();
        chk("collide_frame1_d0", cap_seg[0], seg_tab[4]);
        cap_run();
        chk("collide_frame2_d0", cap_seg[0], seg_tab[10]);
        chk("collide_frame2_d1", cap_seg[1], seg_tab[2]);

        // repeated upd inside one frame: last sample wins
        align(0);
        step(1, 4'h3, 3'd4, 3'd4, 3'd4);
        step(1, 4'h6, 3'd5, 3'd5, 3'd5);
        align(0);
        cap_run();
        chk("last_wins_d0", cap_seg[0], seg_tab[6]);
        chk("last_wins_d3", cap_seg[3], seg_tab[5]);

        // upd held high, then sparse random updates
        repeat (200) step(1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        repeat (1500) step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        // asynchronous reset in the active phase of a slot
        while (exp_an == 4'hF) idle(1);
        #2 rst = 1'b0;
        #1;
        chk("midreset_an", an, 4'hF);
        chk("midreset_sseg", sseg, 7'h7F);
        chk("midreset_dp", dp, 1'b1);
        chk("midreset_fs", frame_start, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk("restart_an", an, 4'b1110);

        // zero entertainment over 130 frames: d1 visibility by frame number
        step(1, 4'h7, 3'd3, 3'd2, 3'd0);
        cnt_a = 0;
        cnt_b = 0;
        while (tq < 130 * FR) begin
            idle(1);
            if (an == 4'b1101) begin
                if (pin_tq / FR < 128) cnt_a++;
                else cnt_b++;
            end
        end
`ifdef SSEG_CRITICAL_BLINK_EN
        chk("blink_d1_frames_0_127", cnt_a, 0);
`else
        chk("steady_d1_frames_0_127", cnt_a, 128 * (DC - BL));
`endif
        chk("d1_frames_128_129", cnt_b, 2 * (DC - BL));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Downstream display stage for the Tamagotchi top level. It consumes the FSM state code and the three pet statistics, then time-multiplexes them onto the 4-digit common-anode seven-segment display.
- Replaces the single-digit static decode. Adds a frame-coherent snapshot, per-digit ghost-blanking, and a fixed scan rate derived from the board clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, full 4-digit refresh rate in Hz. DIGIT_CYCLES = CLK_HZ/(SCAN_HZ*4); minimum 4.
- BLANK_CYCLES, 500, cycles at the start of each digit slot with all anodes off. Must be less than DIGIT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- state  in  4  FSM state code (0..15)
- energy  in  3  energy level (0..7)
- hunger  in  3  hunger level (0..7)
- entertainment  in  3  entertainment level (0..7)
- upd  in  1  one-cycle strobe: sample the four inputs
- sseg  out  7  segments a..g, index 0 = a, active-low
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (rst=0, asynchronous):
  - an=4'b1111, sseg=7'b1111111, dp=1, frame_start=0.
  - Slot counter=0, digit index=0.
  - pending and shadow registers cleared to 0; pend_valid=0.
- Slot counter:
  - Counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On wrap, digit index increments modulo 4 (3 -> 0).
- Digit slot timing:
  - Counter < BLANK_CYCLES: an=1111, sseg=1111111, dp=1.
  - Otherwise: an = one-hot-low of the digit index, and sseg shows that digit's decode.
  - All outputs are registered: one cycle of latency from counter/index to pins.
- Digit mapping, taken from the shadow register:
  - d0 = state
  - d1 = entertainment, zero-extended
  - d2 = hunger, zero-extended
  - d3 = energy, zero-extended
- Decode: hex 0-F, with A,b,C,d,E,F shapes for 10..15.
- dp: lit (0) on d0 only while the state display is active; otherwise 1.
- Snapshot:
  - upd=1 captures the inputs into pending and sets pend_valid.
  - At the cycle the index wraps 3 -> 0, if pend_valid: shadow <= pending, pend_valid <= 0.
  - The displayed frame therefore never mixes two samples.
- Boundary conditions:
  - upd on the same cycle as the 3 -> 0 wrap: the new sample goes to pending only and is applied at the next frame. The old pending is transferred; the new one stays pending.
  - Repeated upd within one frame: last sample wins.
  - upd held high continuously: pending tracks the inputs every cycle; behaviour is unchanged otherwise.
  - frame_start pulses on the first cycle of the digit 0 slot. No pulse on the first slot after reset.
  - Reset asserted mid-slot: all outputs blank within the same cycle (asynchronous); after release, scanning resumes from digit 0, count 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SSEG_CRITICAL_BLINK_EN.
- Defined:
  - Any of d1..d3 whose shadow value is 0 blinks at SCAN_HZ/256 (about 4 Hz at default).
  - An 8-bit frame counter increments on each frame_start; bit 7 low = digit blanked during its active phase (an bit stays 1).
  - The frame counter resets to 0.
  - d0 never blinks.
- Undefined: no frame counter; zero values are displayed steadily as "0".

Decomposition:
- Shared package sseg_pkg:
  - SEG_BLANK = 7'b1111111
  - 16-entry active-low segment pattern constants (SEG_0..SEG_F)
  - digit-index localparams D_STATE=0, D_ENT=1, D_HUN=2, D_ENE=3
- One combinational sub-module, hex7seg_decode: 4-bit value to 7-bit active-low pattern. Instantiated once, fed by a mux on the digit index.
- Counter, snapshot and blink logic stay in the parent.

Test Plan:
All cases use CLK_HZ=4000, SCAN_HZ=100 (DIGIT_CYCLES=10), BLANK_CYCLES=2.
- Reset check: rst=0 mid-slot -> an=1111, sseg=1111111, dp=1 the same cycle; after release, first active phase at cycle 3 is an=1110 showing 0.
- Snapshot: upd with state=5, energy=7, hunger=3, entertainment=0, then 40-cycle frames -> after the next wrap, an=1110/sseg=SEG_5/dp=0, 1101/SEG_0, 1011/SEG_3, 0111/SEG_7. Each digit shows exactly 8 active cycles and 2 blank cycles.
- Frame coherency: upd state=9 at mid digit 2 -> digits 2 and 3 still show the old values; state=9 appears only after the 3 -> 0 wrap.
- Collision: upd(state=A) on the wrap cycle while pending holds state=4 -> frame shows 4, next frame shows A (pattern SEG_A).
- Blanking: sample an on every cycle over 3 frames -> never two bits low at once; 1111 on counts 0-1 of each slot.
- SSEG_CRITICAL_BLINK_EN defined, entertainment=0 -> d1's anode stays 1 for frames 0-127 of each 256-frame cycle; undefined -> d1 shows SEG_0 on every frame.
